// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter with hold limit and enabled 2-to-4 grant decode; request-to-grant latency 1 edge.
// No backpressure: requests are level-sensitive, and a release always leaves one all-low turnaround cycle.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       REQ2,
    input  logic       REQ3,
    output logic       GNT0,
    output logic       GNT1,
    output logic       GNT2,
    output logic       GNT3,
    output logic [1:0] GNT_ID,
    output logic       GNT_VALID
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_vld_q, gnt_vld_d;

    logic [3:0] req_vec;
    logic       pick_vld;
    logic [1:0] pick_id;
    logic [1:0] scan_idx;
    logic       release_now;

    assign req_vec = {REQ3, REQ2, REQ1, REQ0};

    // Search starts at the priority pointer and wraps, so the last winner is tried last.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = ptr_q;
        scan_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!pick_vld && req_vec[scan_idx]) begin
                pick_vld = 1'b1;
                pick_id  = scan_idx;
            end
        end
    end

    assign release_now = !req_vec[gnt_id_q] || !EN || (hcnt_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (EN && pick_vld) begin
                    gnt_id_d  = pick_id;
                    gnt_vld_d = 1'b1;
                    hcnt_d    = 8'd1;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // GNT_ID deliberately keeps its last value through the idle gap.
                if (release_now) begin
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_id_q + 2'd1;
                    hcnt_d    = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    hcnt_d    = hcnt_q + 8'd1;
                end
            end
            default: begin
                gnt_vld_d = 1'b0;
                hcnt_d    = 8'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            hcnt_q    <= 8'd0;
            gnt_id_q  <= 2'd0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign GNT0      = gnt_vld_q & (gnt_id_q == 2'd0);
    assign GNT1      = gnt_vld_q & (gnt_id_q == 2'd1);
    assign GNT2      = gnt_vld_q & (gnt_id_q == 2'd2);
    assign GNT3      = gnt_vld_q & (gnt_id_q == 2'd3);
    assign GNT_ID    = gnt_id_q;
    assign GNT_VALID = gnt_vld_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: two instances (MAX_HOLD 4 and 2) share stimulus and are checked against a reference model.
module tb_rr_decode_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] g_a, g_b;
    logic [1:0] id_a, id_b;
    logic       v_a, v_b;

    rr_decode_arbiter #(.MAX_HOLD(4)) u_dut_a (
        .CLK(clk), .RST(rst), .EN(en),
        .REQ0(req[0]), .REQ1(req[1]), .REQ2(req[2]), .REQ3(req[3]),
        .GNT0(g_a[0]), .GNT1(g_a[1]), .GNT2(g_a[2]), .GNT3(g_a[3]),
        .GNT_ID(id_a), .GNT_VALID(v_a)
    );

    rr_decode_arbiter #(.MAX_HOLD(2)) u_dut_b (
        .CLK(clk), .RST(rst), .EN(en),
        .REQ0(req[0]), .REQ1(req[1]), .REQ2(req[2]), .REQ3(req[3]),
        .GNT0(g_b[0]), .GNT1(g_b[1]), .GNT2(g_b[2]), .GNT3(g_b[3]),
        .GNT_ID(id_b), .GNT_VALID(v_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: who holds the resource, for how long, and where the next search starts.
    int m_vld[2];
    int m_id[2];
    int m_ptr[2];
    int m_held[2];
    int m_lim[2] = '{4, 2};

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0; m_id[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_vld[i] = 0; m_id[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
            end else if (m_vld[i] != 0) begin
                if (!req[m_id[i]] || !en || m_held[i] == m_lim[i]) begin
                    m_vld[i]  = 0;
                    m_ptr[i]  = (m_id[i] + 1) % 4;
                    m_held[i] = 0;
                end else begin
                    m_held[i] = m_held[i] + 1;
                end
            end else if (en && req != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[(m_ptr[i] + k) % 4]) m_id[i] = (m_ptr[i] + k) % 4;
                end
                m_vld[i]  = 1;
                m_held[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_gnt",   {4'b0, g_a},  (m_vld[0] != 0) ? 8'(1 << m_id[0]) : 8'd0);
            check("a_id",    {6'b0, id_a}, 8'(m_id[0]));
            check("a_valid", {7'b0, v_a},  8'(m_vld[0]));
            check("b_gnt",   {4'b0, g_b},  (m_vld[1] != 0) ? 8'(1 << m_id[1]) : 8'd0);
            check("b_id",    {6'b0, id_b}, 8'(m_id[1]));
            check("b_valid", {7'b0, v_b},  8'(m_vld[1]));
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        en  = e;
        req = q;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
    endtask

    initial begin
        // Reset held with everything requesting
        step(1'b1, 1'b1, 4'b1111);
        check("rst_gnt",   {4'b0, g_a}, 8'h00);
        check("rst_valid", {7'b0, v_a}, 8'h00);
        check("rst_id",    {6'b0, id_a}, 8'h00);
        step(1'b1, 1'b1, 4'b1111);
        check("rst2_gnt", {4'b0, g_a}, 8'h00);

        // Fairness: grant edge is cycle 0, period of 5 per agent
        step(1'b0, 1'b1, 4'b1111);
        check("first_gnt", {4'b0, g_a}, 8'h01);
        check("first_id",  {6'b0, id_a}, 8'h00);
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 1'b1, 4'b1111);
            check("rr_seq", {4'b0, g_a}, (c % 5 == 4) ? 8'd0 : 8'(1 << ((c / 5) % 4)));
        end

        // Early release, then REQ3 alone for two edges, then wrap to agent 0
        step(1'b0, 1'b1, 4'b0000);
        check("drop_all", {4'b0, g_a}, 8'h00);
        step(1'b0, 1'b1, 4'b1000);
        check("g3_first", {4'b0, g_a}, 8'h08);
        step(1'b0, 1'b1, 4'b1000);
        check("g3_second", {4'b0, g_a}, 8'h08);
        step(1'b0, 1'b1, 4'b0000);
        check("g3_release", {4'b0, g_a}, 8'h00);
        check("g3_id_kept", {6'b0, id_a}, 8'h03);
        step(1'b0, 1'b1, 4'b1001);
        check("wrap_to_0", {4'b0, g_a}, 8'h01);
        step(1'b0, 1'b1, 4'b0000);

        // EN gating
        step(1'b0, 1'b0, 4'b0010);
        check("en_low_a", {4'b0, g_a}, 8'h00);
        step(1'b0, 1'b0, 4'b0010);
        check("en_low_b", {4'b0, g_a}, 8'h00);
        step(1'b0, 1'b1, 4'b0010);
        check("en_rise", {4'b0, g_a}, 8'h02);
        step(1'b0, 1'b1, 4'b0010);
        check("en_hold", {4'b0, g_a}, 8'h02);
        step(1'b0, 1'b0, 4'b0110);
        check("en_drop", {4'b0, g_a}, 8'h00);
        step(1'b0, 1'b1, 4'b0110);
        check("after_en_2", {4'b0, g_a}, 8'h04);
        step(1'b0, 1'b1, 4'b0000);

        // REQ2 drop coincides with hold expiry on the MAX_HOLD=2 instance
        step(1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b1100);
        check("sim_a_g2", {4'b0, g_a}, 8'h04);
        check("sim_b_g2", {4'b0, g_b}, 8'h04);
        step(1'b0, 1'b1, 4'b1100);
        check("sim_b_hold", {4'b0, g_b}, 8'h04);
        step(1'b0, 1'b1, 4'b1000);
        check("sim_b_rel", {4'b0, g_b}, 8'h00);
        step(1'b0, 1'b1, 4'b1001);
        check("sim_b_ptr3", {4'b0, g_b}, 8'h08);
        check("sim_a_ptr3", {4'b0, g_a}, 8'h08);

        // Reset during the GNT3 grant
        step(1'b1, 1'b1, 4'b1001);
        check("mid_rst_gnt", {4'b0, g_a}, 8'h00);
        check("mid_rst_id",  {6'b0, id_a}, 8'h00);
        step(1'b0, 1'b1, 4'b1111);
        check("post_rst_a", {4'b0, g_a}, 8'h01);
        check("post_rst_b", {4'b0, g_b}, 8'h01);

        // Mixed traffic checked by the model only
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 4'($urandom));
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Four-requester round-robin arbiter for a shared resource. It registers a 2-bit grant index and a grant-valid flag. The one-hot grant lines are the enabled 2-to-4 decode of that index, with the grant-valid flag acting as the enable. It sits between four requesting agents and the resource select logic, replacing the free-running 2-to-4 select with a sequenced, fair, hold-limited grant.

## Interface
- MAX_HOLD, 4: maximum consecutive cycles one grant may be held. Legal range 1..255. The hold counter is 8 bits.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  arbitration enable. Low blocks new grants and forces release of the current one.
- REQ0..REQ3  input  1 each  request from agent 0..3, level-sensitive.
- GNT0..GNT3  output  1 each  one-hot grant. GNTi = GNT_VALID & (GNT_ID == i). Combinational decode of registered state only.
- GNT_ID  output  2  index of the granted agent. Registered.
- GNT_VALID  output  1  a grant is active. Registered.

## Operation
- Internal state:
  - FSM state IDLE/GRANT.
  - 2-bit priority pointer PTR.
  - 8-bit hold counter HCNT.
- Reset, applied at the CLK edge with RST=1:
  - state=IDLE, PTR=0, HCNT=0.
  - GNT_ID=0, GNT_VALID=0, so GNT0..GNT3=0.
  - RST overrides all other inputs.
- IDLE:
  - If EN=1 and any REQi=1, pick the first requesting agent in order PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - At that edge: GNT_ID=winner, GNT_VALID=1, HCNT=1, go to GRANT.
  - Otherwise stay in IDLE with outputs unchanged (GNT_VALID=0).
- GRANT:
  - Release happens at an edge where any of these hold:
    - REQ[GNT_ID]=0;
    - EN=0;
    - HCNT==MAX_HOLD.
  - On release: GNT_VALID=0, PTR=GNT_ID+1 (mod 4, wrap 3->0), HCNT=0, go to IDLE. GNT_ID keeps its last value.
  - Otherwise: HCNT=HCNT+1 and the grant is held.
- Requests from non-granted agents never preempt a grant.
- Requests need not be held; an agent that drops REQ before being granted is simply not selected.
- Exactly one GNTi is high whenever GNT_VALID=1. All are low otherwise.

## Timing
- Grant latency: REQi sampled high in IDLE produces GNTi high in the next cycle (1 edge).
- Every release is followed by at least one cycle with all GNT low, which is the bus turnaround. Back-to-back grants are therefore spaced by at least one idle cycle.
- Hold limit: a continuously requesting agent gets exactly MAX_HOLD cycles of GNT, then 1 cycle low. It is re-granted only if no other agent is requesting.
- MAX_HOLD=1: every grant lasts exactly one cycle.
- Simultaneous release causes (REQ drop, EN=0, hold expiry) on one edge: single release, PTR advanced once.
- PTR advances only on release, never on reset or in IDLE.
- RST asserted mid-grant: GNT low from the next edge, and PTR returns to 0.

## Test plan
- Reset: drive RST=1 for 2 cycles with all REQ=1 and EN=1 -> GNT0..3=0, GNT_VALID=0 and GNT_ID=0 while reset is applied. The first edge after RST falls -> GNT0=1, GNT_ID=0.
- Round-robin fairness:
  - Stimulus: MAX_HOLD=4, EN=1, REQ0..REQ3 held high.
  - Required: grant order 0,1,2,3,0, each grant 4 cycles high followed by 1 cycle all-low, giving a 20-cycle period.
- Early release and wrap:
  - Stimulus: only REQ3 high, pulsed for 2 cycles.
  - Required: GNT3 high for 2 cycles after 1-cycle latency.
  - Next, stimulus: REQ0 and REQ3 both high. Required: GNT0 wins because PTR wrapped to 0.
- EN gating:
  - Stimulus: EN=0 with REQ1 high. Required: no grant.
  - Stimulus: raise EN. Required: GNT1 on the next edge.
  - Stimulus: drop EN during the grant. Required: GNT1 low after one edge, and the next grant goes to agent 2 if it requests.
- Simultaneous events:
  - Stimulus: with MAX_HOLD=2, REQ2 drops on the same edge its HCNT reaches 2, with REQ2 and REQ3 active. Required: single release, PTR=3.
  - Stimulus: RST pulsed during a GNT3 grant. Required: GNT low on the next edge, and REQ0..3 all high afterwards gives GNT0.
